// File: rtl/dm_pkg.sv
// Shared types and constants for the byte-serial data-memory access unit:
// DMType codes, FSM state encoding, request payload and size/alignment helpers.
package dm_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned DMTYPE_W = 3;

  localparam logic [DMTYPE_W-1:0] DM_WORD   = 3'b000;
  localparam logic [DMTYPE_W-1:0] DM_HALF   = 3'b001;
  localparam logic [DMTYPE_W-1:0] DM_HALF_U = 3'b010;
  localparam logic [DMTYPE_W-1:0] DM_BYTE   = 3'b011;
  localparam logic [DMTYPE_W-1:0] DM_BYTE_U = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic                we;
    logic [DMTYPE_W-1:0] dmtype;
    logic [DATA_W-1:0]   wdata;
  } dm_req_t;

  // Number of byte transfers; reserved codes behave as word.
  function automatic logic [2:0] dm_nbytes(input logic [DMTYPE_W-1:0] dmtype);
    case (dmtype)
      DM_HALF, DM_HALF_U: return 3'd2;
      DM_BYTE, DM_BYTE_U: return 3'd1;
      default:            return 3'd4;
    endcase
  endfunction

  function automatic logic dm_misaligned(input logic [DMTYPE_W-1:0] dmtype,
                                         input logic [1:0]          addr_lo);
    logic [2:0] n;
    n = dm_nbytes(dmtype);
    return ((n == 3'd2) && addr_lo[0]) || ((n == 3'd4) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Core-request and byte-wide SRAM port bundle for dm_access_unit.
// master = core/memory environment view, slave = access-unit view.
interface dm_access_unit_if import dm_pkg::*; #(
  parameter int unsigned ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [DMTYPE_W-1:0] req_dmtype;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [BYTE_W-1:0]   mem_wdata;
  logic [BYTE_W-1:0]   mem_rdata;
  logic                mem_ack;

  modport master (
    output req_valid, req_we, req_dmtype, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  req_valid, req_we, req_dmtype, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/dm_load_ext.sv
// Sign/zero extension of an assembled little-endian load value by DMType.
module dm_load_ext import dm_pkg::*; (
  input  logic [DATA_W-1:0]   raw,
  input  logic [DMTYPE_W-1:0] dmtype,
  output logic [DATA_W-1:0]   ext_c
);
  always_comb begin
    ext_c = raw;
    case (dmtype)
      DM_HALF:   ext_c = {{16{raw[15]}}, raw[15:0]};
      DM_HALF_U: ext_c = {16'h0000, raw[15:0]};
      DM_BYTE:   ext_c = {{24{raw[7]}}, raw[7:0]};
      DM_BYTE_U: ext_c = {24'h000000, raw[7:0]};
      default:   ext_c = raw;
    endcase
  end
endmodule

// File: rtl/dm_access_unit.sv
// Load/store unit: sequences one 32-bit core access as 1/2/4 byte transfers
// on a byte-wide SRAM port. Optional DM_MISALIGN_TRAP_EN rejects misaligned half/word.
module dm_access_unit import dm_pkg::*; #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  dm_access_unit_if.slave   bus
);
  localparam int unsigned IDX_W = 2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt_c;
  logic [2:0]        nbytes_q, nbytes_d;
  dm_req_t           req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, data_upd_c, ext_c;
  logic              misalign_c, last_c;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;

  dm_load_ext u_load_ext (
    .raw    (data_upd_c),
    .dmtype (req_q.dmtype),
    .ext_c  (ext_c)
  );

  always_comb begin
`ifdef DM_MISALIGN_TRAP_EN
    misalign_c = dm_misaligned(bus.req_dmtype, bus.req_addr[1:0]);
`else
    misalign_c = 1'b0;
`endif
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    nbytes_d     = nbytes_q;
    req_d        = req_q;
    addr_d       = addr_q;
    data_d       = data_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    idx_nxt_c    = idx_q + IDX_W'(1);
    last_c       = ({1'b0, idx_q} == (nbytes_q - 3'd1));
    data_upd_c   = data_q;
    data_upd_c[{idx_q, 3'b000} +: BYTE_W] = bus.mem_rdata;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_d       = '{we: bus.req_we, dmtype: bus.req_dmtype, wdata: bus.req_wdata};
          addr_d      = bus.req_addr;
          idx_d       = '0;
          nbytes_d    = dm_nbytes(bus.req_dmtype);
          data_d      = '0;
          req_ready_d = 1'b0;
          if (misalign_c) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ST_XFER;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata[BYTE_W-1:0];
          end
        end
      end
      ST_XFER: begin
        mem_req_d = 1'b1;
        mem_we_d  = mem_we_q;
        if (bus.mem_ack) begin
          data_d = data_upd_c;
          if (last_c) begin
            state_d      = ST_DONE;
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_rdata_d = req_q.we ? '0 : ext_c;
          end else begin
            idx_d       = idx_nxt_c;
            mem_addr_d  = addr_q + ADDR_W'(idx_nxt_c);
            mem_wdata_d = req_q.wdata[{idx_nxt_c, 3'b000} +: BYTE_W];
          end
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      nbytes_q     <= '0;
      req_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      nbytes_q     <= nbytes_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
